// File: rtl/axis_mux_pkg.sv
// axis_mux_pkg
//   Shared types and helpers for the N-input AXI-Stream multiplexer.
//   - arb_state_t : arbiter FSM state (IDLE = no packet in flight, LOCK = mid-packet)
//   - rr_next()   : round-robin pointer advance with explicit wrap at n_ch,
//                   so non-power-of-2 channel counts work.
package axis_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int ptr, input int n_ch);
        return (ptr >= n_ch - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf
//   Two-entry register FIFO with valid/ready on both sides. The output comes
//   straight from the head register, and s_ready comes from a registered full
//   flag, so no combinational path exists from m_ready to s_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_data/s_valid      write side; s_ready = not full
//   m_data/m_valid      head entry; m_valid = buffer non-empty
//   m_ready             pops the head when m_valid is high
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         head_vld_q;
    logic         full_q;      // both entries occupied
    logic         push;
    logic         pop;

    assign s_ready = ~full_q;
    assign push    = s_valid & ~full_q;
    assign pop     = head_vld_q & m_ready;
    assign m_data  = head_q;
    assign m_valid = head_vld_q;

    // NOTE: the storage registers are reset too: the outputs must read zero
    // out of reset, and the entries are only two words wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            full_q     <= 1'b0;
        end else if (full_q) begin
            // Push is blocked while full; only a pop can change state.
            if (pop) begin
                head_q <= tail_q;
                full_q <= 1'b0;
            end
        end else if (head_vld_q) begin
            if (push && pop) begin
                head_q <= s_data;
            end else if (push) begin
                tail_q <= s_data;
                full_q <= 1'b1;
            end else if (pop) begin
                head_vld_q <= 1'b0;
            end
        end else if (push) begin
            head_q     <= s_data;
            head_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_mux_n.sv
// axis_mux_n
//   N-input AXI-Stream multiplexer with packet-aware arbitration. The grant is
//   held from the first beat of a packet through its TLAST beat. Selection is
//   by external sel (ARB_MODE 0) or round-robin over valid channels
//   (ARB_MODE 1). The output is registered through a 2-entry skid buffer.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   sel                  requested channel (mode 0 only)
//   s_tdata/tvalid/tlast packed per-channel inputs, channel i at slice i
//   s_tready             per-channel ready, one-hot or zero
//   m_tdata/tvalid/tlast output stream, m_tdest = source channel of the beat
//   m_tready             downstream ready
module axis_mux_n
    import axis_mux_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_CH     = 4,
    parameter int ARB_MODE = 0,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    input  logic [N_CH-1:0]        s_tlast,
    output logic [N_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    output logic [SEL_W-1:0]       m_tdest,
    input  logic                   m_tready
);

    localparam int BUF_W = DATA_W + 1 + SEL_W;

    arb_state_t        state_q;
    logic [SEL_W-1:0]  gnt_q;
    logic [SEL_W-1:0]  rr_ptr;
    logic              run_q;        // low during and one cycle after reset

    logic              grant_active;
    logic [SEL_W-1:0]  gnt;
    logic [DATA_W-1:0] cur_data;
    logic              cur_valid;
    logic              cur_last;
    logic              accept;
    logic              buf_ready;
    logic [BUF_W-1:0]  buf_out;

    // Grant selection. In mode 1 the search runs downward over offsets from
    // rr_ptr so the lowest offset with a valid channel is the final winner.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx          = 0;
        grant_active = 1'b0;
        gnt          = gnt_q;
        if (!run_q) begin
            grant_active = 1'b0;
        end else if (state_q == LOCK) begin
            grant_active = 1'b1;
        end else if (ARB_MODE == 0) begin
            if (int'(sel) < N_CH) begin
                grant_active = 1'b1;
                gnt          = sel;
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (s_tvalid[idx]) begin
                    grant_active = 1'b1;
                    gnt          = SEL_W'(idx);
                end
            end
        end
    end

    // Grant mux and one-hot ready decode.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        s_tready  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == gnt) begin
                cur_data    = s_tdata[i*DATA_W +: DATA_W];
                cur_valid   = s_tvalid[i];
                cur_last    = s_tlast[i];
                s_tready[i] = grant_active & buf_ready;
            end
        end
    end

    assign accept = grant_active & buf_ready & cur_valid;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_ptr  <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                gnt_q <= gnt;
                if (cur_last) begin
                    state_q <= IDLE;
                    if (ARB_MODE == 1) rr_ptr <= SEL_W'(rr_next(int'(gnt), N_CH));
                end else begin
                    state_q <= LOCK;
                end
            end
        end
    end

    axis_skid_buf #(
        .W (BUF_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .s_data  ({cur_data, cur_last, gnt}),
        .s_valid (accept),
        .s_ready (buf_ready),
        .m_data  (buf_out),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

    assign m_tdata = buf_out[BUF_W-1 -: DATA_W];
    assign m_tlast = buf_out[SEL_W];
    assign m_tdest = buf_out[SEL_W-1:0];

endmodule

// File: tb/tb_axis_mux_n.sv
// tb_axis_mux_n
//   Directed bench for axis_mux_n. Three instances share clk and reset:
//   u0 = 4 channels, sel mode; u1 = 4 channels, round-robin; u2 = 3 channels,
//   sel mode (for the out-of-range sel case). Inputs are driven 1 time unit
//   after the rising edge; outputs are sampled there as well.
module tb_axis_mux_n;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // u0: N_CH=4, ARB_MODE=0
    logic [1:0]  sel0;
    logic [31:0] td0;
    logic [3:0]  tv0, tl0, tr0;
    logic [7:0]  md0;
    logic        mv0, ml0, mr0;
    logic [1:0]  mdst0;

    // u1: N_CH=4, ARB_MODE=1
    logic [1:0]  sel1;
    logic [31:0] td1;
    logic [3:0]  tv1, tl1, tr1;
    logic [7:0]  md1;
    logic        mv1, ml1, mr1;
    logic [1:0]  mdst1;

    // u2: N_CH=3, ARB_MODE=0
    logic [1:0]  sel2;
    logic [23:0] td2;
    logic [2:0]  tv2, tl2, tr2;
    logic [7:0]  md2;
    logic        mv2, ml2, mr2;
    logic [1:0]  mdst2;

    int n_checks = 0;
    int n_errors = 0;

    axis_mux_n #(.DATA_W(8), .N_CH(4), .ARB_MODE(0)) u0 (
        .clk(clk), .reset(reset), .sel(sel0),
        .s_tdata(td0), .s_tvalid(tv0), .s_tlast(tl0), .s_tready(tr0),
        .m_tdata(md0), .m_tvalid(mv0), .m_tlast(ml0), .m_tdest(mdst0),
        .m_tready(mr0)
    );

    axis_mux_n #(.DATA_W(8), .N_CH(4), .ARB_MODE(1)) u1 (
        .clk(clk), .reset(reset), .sel(sel1),
        .s_tdata(td1), .s_tvalid(tv1), .s_tlast(tl1), .s_tready(tr1),
        .m_tdata(md1), .m_tvalid(mv1), .m_tlast(ml1), .m_tdest(mdst1),
        .m_tready(mr1)
    );

    axis_mux_n #(.DATA_W(8), .N_CH(3), .ARB_MODE(0)) u2 (
        .clk(clk), .reset(reset), .sel(sel2),
        .s_tdata(td2), .s_tvalid(tv2), .s_tlast(tl2), .s_tready(tr2),
        .m_tdata(md2), .m_tvalid(mv2), .m_tlast(ml2), .m_tdest(mdst2),
        .m_tready(mr2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_tr;
        reset = 1'b0;
        sel0 = '0; td0 = '0; tv0 = '0; tl0 = '0; mr0 = 1'b1;
        sel1 = '0; td1 = '0; tv1 = '0; tl1 = '0; mr1 = 1'b1;
        sel2 = '0; td2 = '0; tv2 = '0; tl2 = '0; mr2 = 1'b1;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        check("rst_mvalid", 32'(mv0), 32'd0);
        check("rst_tready", 32'(tr0), 32'd0);
        check("rst_mdata",  32'(md0), 32'd0);
        check("rst_mtdest", 32'(mdst0), 32'd0);
        check("rst_mtlast", 32'(ml0), 32'd0);
        reset = 1'b1;
        cyc();

        // ---------------- first beat, sel=1 ----------------
        sel0 = 2'd1; td0 = 32'h0000_2200; tv0 = 4'b0010; tl0 = 4'b0010;
        #1 check("t1_tready", 32'(tr0), 32'b0010);
        cyc();
        check("t1_mvalid", 32'(mv0), 32'd1);
        check("t1_mdata",  32'(md0), 32'h22);
        check("t1_mdest",  32'(mdst0), 32'd1);
        check("t1_mlast",  32'(ml0), 32'd1);
        tv0 = '0; tl0 = '0;
        cyc();
        check("t1_drain", 32'(mv0), 32'd0);

        // ---------------- packet lock, sel toggles mid-packet ----------------
        sel0 = 2'd0; td0 = 32'h0000_0033; tv0 = 4'b0001; tl0 = 4'b0000;
        #1 check("lk_rdy0", 32'(tr0), 32'b0001);
        cyc();
        check("lk_d33", 32'(md0), 32'h33);
        check("lk_dst33", 32'(mdst0), 32'd0);
        sel0 = 2'd2; td0 = 32'h00AA_0044; tv0 = 4'b0101; tl0 = 4'b0100;
        #1 check("lk_rdy_hold1", 32'(tr0), 32'b0001);
        cyc();
        check("lk_d44", 32'(md0), 32'h44);
        check("lk_dst44", 32'(mdst0), 32'd0);
        td0 = 32'h00AA_0055; tl0 = 4'b0101;
        #1 check("lk_rdy_hold2", 32'(tr0), 32'b0001);
        cyc();
        check("lk_d55", 32'(md0), 32'h55);
        check("lk_l55", 32'(ml0), 32'd1);
        check("lk_dst55", 32'(mdst0), 32'd0);
        tv0 = 4'b0100;
        #1 check("lk_rdy_ch2", 32'(tr0), 32'b0100);
        cyc();
        check("lk_dAA", 32'(md0), 32'hAA);
        check("lk_dstAA", 32'(mdst0), 32'd2);
        tv0 = '0; tl0 = '0;
        cyc();
        check("lk_drain", 32'(mv0), 32'd0);

        // ---------------- backpressure ----------------
        sel0 = 2'd0; mr0 = 1'b0; td0 = 32'h0000_0055; tv0 = 4'b0001; tl0 = 4'b0000;
        #1 check("bp_rdy_b1", 32'(tr0), 32'b0001);
        cyc();
        td0 = 32'h0000_0066;
        #1 check("bp_rdy_b2", 32'(tr0), 32'b0001);
        check("bp_hold55a", 32'(md0), 32'h55);
        cyc();
        td0 = 32'h0000_0012; tl0 = 4'b0001;
        #1 check("bp_rdy_full1", 32'(tr0), 32'b0000);
        cyc();
        check("bp_rdy_full2", 32'(tr0), 32'b0000);
        check("bp_hold55b", 32'(md0), 32'h55);
        check("bp_mvalid", 32'(mv0), 32'd1);
        cyc();
        mr0 = 1'b1;
        #1 check("bp_rdy_full3", 32'(tr0), 32'b0000);
        check("bp_out55", 32'(md0), 32'h55);
        cyc();
        check("bp_out66", 32'(md0), 32'h66);
        check("bp_last66", 32'(ml0), 32'd0);
        check("bp_rdy_reopen", 32'(tr0), 32'b0001);
        cyc();
        check("bp_out12", 32'(md0), 32'h12);
        check("bp_last12", 32'(ml0), 32'd1);
        tv0 = '0; tl0 = '0;
        cyc();
        check("bp_drain", 32'(mv0), 32'd0);

        // ---------------- round-robin (u1) ----------------
        sel1 = 2'd2; td1 = 32'h1312_1110; tv1 = 4'hF; tl1 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_tr = 4'b0001 << (k % 4);
            #1 check($sformatf("rr_rdy%0d", k), 32'(tr1), 32'(exp_tr));
            cyc();
            check($sformatf("rr_data%0d", k), 32'(md1), 32'h10 + 32'(k % 4));
            check($sformatf("rr_dest%0d", k), 32'(mdst1), 32'(k % 4));
        end
        tv1 = '0; tl1 = '0;
        cyc();
        check("rr_drain", 32'(mv1), 32'd0);

        // ---------------- out-of-range sel (u2, N_CH=3) ----------------
        sel2 = 2'd3; td2 = 24'h03_0201; tv2 = 3'b111; tl2 = 3'b111;
        #1 check("inv_rdy", 32'(tr2), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("inv_mvalid%0d", k), 32'(mv2), 32'd0);
            check($sformatf("inv_rdy%0d", k), 32'(tr2), 32'd0);
        end
        sel2 = 2'd2;
        #1 check("inv_rdy_sel2", 32'(tr2), 32'b100);
        cyc();
        check("inv_data_sel2", 32'(md2), 32'h03);
        check("inv_dest_sel2", 32'(mdst2), 32'd2);
        tv2 = '0; tl2 = '0;
        cyc();

        // ---------------- reset mid-packet (u0) ----------------
        sel0 = 2'd1; mr0 = 1'b0; td0 = 32'h0000_0100; tv0 = 4'b0010; tl0 = 4'b0000;
        cyc();
        td0 = 32'h0000_0200;
        cyc();
        check("mr_pre_mvalid", 32'(mv0), 32'd1);
        check("mr_pre_data", 32'(md0), 32'h01);
        reset = 1'b0;
        #1 check("mr_mvalid", 32'(mv0), 32'd0);
        check("mr_tready", 32'(tr0), 32'd0);
        check("mr_mdata", 32'(md0), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        // ch1 still valid: an FSM stuck in LOCK would keep granting ch1.
        sel0 = 2'd2; td0 = 32'h0077_0300; tv0 = 4'b0110; tl0 = 4'b0100; mr0 = 1'b1;
        #1 check("mr_rdy_ch2", 32'(tr0), 32'b0100);
        cyc();
        check("mr_data77", 32'(md0), 32'h77);
        check("mr_dest2", 32'(mdst0), 32'd2);
        check("mr_last", 32'(ml0), 32'd1);
        tv0 = '0; tl0 = '0;
        cyc();
        check("mr_drain", 32'(mv0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
